// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the in-order pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package riscv_pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_LOAD_IN,
    MAIN_LOAD_SKID,
    MAIN_CLEAR
  } main_op_t;

  typedef enum logic [1:0] {
    SKID_HOLD,
    SKID_LOAD_IN,
    SKID_CLEAR
  } skid_op_t;

endpackage

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer; in_ready is a pure flop output.
module if_id_skid_reg
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PC_W      = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(RV_NOP)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  pipe_state_t        state, state_nxt;
  main_op_t           main_op;
  skid_op_t           skid_op;
  logic               accept, deliver;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  always_comb begin
    accept    = in_valid & in_ready;
    deliver   = out_valid & out_ready;
    state_nxt = state;
    main_op   = MAIN_HOLD;
    skid_op   = SKID_HOLD;
    if (flush) begin
      state_nxt = EMPTY;
      main_op   = MAIN_CLEAR;
      skid_op   = SKID_CLEAR;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_op   = MAIN_LOAD_IN;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_op = MAIN_LOAD_IN;
          end else if (accept) begin
            state_nxt = FULL;
            skid_op   = SKID_LOAD_IN;
          end else if (deliver) begin
            state_nxt = EMPTY;
            main_op   = MAIN_CLEAR;
          end
        end
        FULL: begin
          // Skid drains into main only; accept is impossible here since in_ready=0.
          if (deliver) begin
            state_nxt = ONE;
            main_op   = MAIN_LOAD_SKID;
            skid_op   = SKID_CLEAR;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_op   = MAIN_CLEAR;
          skid_op   = SKID_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_instr <= NOP_INSTR;
      out_pc    <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      case (main_op)
        MAIN_LOAD_IN: begin
          out_instr <= in_instr;
          out_pc    <= in_pc;
        end
        MAIN_LOAD_SKID: begin
          out_instr <= skid_instr;
          out_pc    <= skid_pc;
        end
        MAIN_CLEAR: begin
          out_instr <= NOP_INSTR;
          out_pc    <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else begin
      case (skid_op)
        SKID_LOAD_IN: begin
          skid_instr <= in_instr;
          skid_pc    <= in_pc;
        end
        SKID_CLEAR: begin
          skid_instr <= NOP_INSTR;
          skid_pc    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios plus random traffic against a 2-deep FIFO model.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        in_ready16, out_valid16;
  logic [15:0] out_instr16;
  logic [31:0] out_pc16;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } word_t;
  word_t q[$];

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  if_id_skid_reg #(.INSTR_W(16), .PC_W(32), .NOP_INSTR(16'h0001)) dut16 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready16), .in_instr(in_instr[15:0]), .in_pc(in_pc[31:0]),
    .out_valid(out_valid16), .out_ready(out_ready), .out_instr(out_instr16), .out_pc(out_pc16)
  );

  // Model: up to two words held in order; ready means room was left after the last edge.
  task automatic tick();
    bit acc, del;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    del = (q.size() > 0) && out_ready;
    if (!reset_n || flush) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back('{in_instr, in_pc});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_instr = $urandom; in_pc = {$urandom, $urandom};
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0 || out_instr !== 32'h00000013 || out_pc !== 64'd0 || in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_hold: got v=%b i=%h pc=%h r=%b, want v=0 i=00000013 pc=0 r=1",
                 out_valid, out_instr, out_pc, in_ready);
      end
    end
    q.delete();
    in_instr = 32'hDEAD0001; in_pc = 64'h800; reset_n = 1'b1;
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_instr !== 32'hDEAD0001 || out_pc !== 64'h800) begin
      mismatched++;
      $display("FAIL reset_release: got v=%b i=%h pc=%h, want v=1 i=dead0001 pc=800",
               out_valid, out_instr, out_pc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    compared++;
    if (out_valid !== 1'b0 || out_instr !== 32'h00000013 || out_pc !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_drain: got v=%b i=%h pc=%h, want v=0 i=00000013 pc=0",
               out_valid, out_instr, out_pc);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_instr = 32'hA0000000 + 32'(k);
      in_pc    = 64'h1000 + 64'(4 * k);
      tick();
      compared++;
      if (out_valid !== 1'b1 || out_instr !== 32'hA0000000 + 32'(k) ||
          out_pc !== 64'h1000 + 64'(4 * k) || in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL stream k=%0d: got v=%b i=%h pc=%h r=%b, want v=1 i=%h pc=%h r=1",
                 k, out_valid, out_instr, out_pc, in_ready, 32'hA0000000 + 32'(k), 64'h1000 + 64'(4 * k));
      end
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (out_valid !== 1'b0 || out_instr !== 32'h00000013) begin
      mismatched++;
      $display("FAIL stream_end: got v=%b i=%h, want v=0 i=00000013", out_valid, out_instr);
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_pc [4];
    logic        exp_rdy [4];
    exp_pc  = '{64'h1108, 64'h1108, 64'h110C, 64'h1110};
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      in_instr = 32'hB0000000 + 32'(j); in_pc = 64'h1100 + 64'(4 * j);
      tick();
    end
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin in_instr = 32'hB0000003; in_pc = 64'h110C; out_ready = 1'b0; end
      if (s == 1) begin in_instr = 32'hB0000004; in_pc = 64'h1110; end
      if (s == 2) out_ready = 1'b1;
      tick();
      compared++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[s] || in_ready !== exp_rdy[s] ||
          out_instr !== 32'hB0000000 + 32'((exp_pc[s] - 64'h1100) >> 2)) begin
        mismatched++;
        $display("FAIL stall s=%0d: got v=%b i=%h pc=%h r=%b, want v=1 pc=%h r=%b",
                 s, out_valid, out_instr, out_pc, in_ready, exp_pc[s], exp_rdy[s]);
      end
    end
    in_valid = 1'b0;
    tick();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_drain: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hC0002100; in_pc = 64'h2100; tick();
    in_instr = 32'hC0002104; in_pc = 64'h2104; tick();
    compared++;
    if (in_ready !== 1'b0 || out_pc !== 64'h2100) begin
      mismatched++;
      $display("FAIL flush_fill: got r=%b pc=%h, want r=0 pc=2100", in_ready, out_pc);
    end
    flush = 1'b1; in_instr = $urandom; in_pc = 64'h2000; tick();
    compared++;
    if (out_valid !== 1'b0 || out_instr !== 32'h00000013 || out_pc !== 64'd0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_full: got v=%b i=%h pc=%h r=%b, want v=0 i=00000013 pc=0 r=1",
               out_valid, out_instr, out_pc, in_ready);
    end
    flush = 1'b0; in_instr = 32'hC0003000; in_pc = 64'h3000; out_ready = 1'b1; tick();
    compared++;
    if (out_valid !== 1'b1 || out_pc !== 64'h3000 || out_instr !== 32'hC0003000) begin
      mismatched++;
      $display("FAIL flush_next: got v=%b i=%h pc=%h, want v=1 i=c0003000 pc=3000",
               out_valid, out_instr, out_pc);
    end
    // Flush in ONE while an accept is offered: both the held word and the offered one vanish.
    flush = 1'b1; in_instr = 32'hC0002000; in_pc = 64'h2000; tick();
    flush = 1'b0; in_valid = 1'b0; tick();
    compared++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_one_drop: got v=%b pc=%h r=%b, want v=0 pc=0 r=1", out_valid, out_pc, in_ready);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || out_instr !== 32'h00000013 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_empty: got v=%b i=%h r=%b, want v=0 i=00000013 r=1", out_valid, out_instr, in_ready);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hD0000001; in_pc = 64'h4000; tick();
    in_instr = 32'hD0000002; in_pc = 64'h4004; tick();
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    compared++;
    if (out_valid !== 1'b0 || out_instr !== 32'h00000013 || out_pc !== 64'd0 || in_ready !== 1'b1 ||
        out_valid16 !== 1'b0 || out_instr16 !== 16'h0001) begin
      mismatched++;
      $display("FAIL async_reset: got v=%b i=%h pc=%h r=%b i16=%h, want v=0 i=00000013 pc=0 r=1 i16=0001",
               out_valid, out_instr, out_pc, in_ready, out_instr16);
    end
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL async_reset_after: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] ei;
    logic [63:0] ep;
    logic        hold_chk, pv;
    logic [31:0] pi;
    logic [63:0] pp;
    for (int c = 0; c < 300; c++) begin
      if (!(in_valid && q.size() == 2)) begin
        in_valid = 1'($urandom_range(0, 1)); in_instr = $urandom; in_pc = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      hold_chk = out_valid && !out_ready && !flush;
      pv = out_valid; pi = out_instr; pp = out_pc;
      tick();
      ei = (q.size() > 0) ? q[0].instr : 32'h00000013;
      ep = (q.size() > 0) ? q[0].pc : 64'd0;
      compared++;
      if (out_valid !== (q.size() > 0) || out_instr !== ei || out_pc !== ep || in_ready !== (q.size() < 2)) begin
        mismatched++;
        $display("FAIL random c=%0d: got v=%b i=%h pc=%h r=%b, want v=%b i=%h pc=%h r=%b",
                 c, out_valid, out_instr, out_pc, in_ready, q.size() > 0, ei, ep, q.size() < 2);
      end
      if (hold_chk) begin
        compared++;
        if (out_valid !== pv || out_instr !== pi || out_pc !== pp) begin
          mismatched++;
          $display("FAIL stall_hold c=%0d: got v=%b i=%h pc=%h, want v=%b i=%h pc=%h",
                   c, out_valid, out_instr, out_pc, pv, pi, pp);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_params();
    logic [15:0] ei;
    logic [31:0] ep;
    logic        hold_chk;
    logic [15:0] pi;
    logic [31:0] pp;
    for (int c = 0; c < 200; c++) begin
      if (!(in_valid && q.size() == 2)) begin
        in_valid = 1'($urandom_range(0, 1)); in_instr = $urandom; in_pc = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      hold_chk = out_valid16 && !out_ready && !flush;
      pi = out_instr16; pp = out_pc16;
      tick();
      ei = (q.size() > 0) ? q[0].instr[15:0] : 16'h0001;
      ep = (q.size() > 0) ? q[0].pc[31:0] : 32'd0;
      compared++;
      if (out_valid16 !== (q.size() > 0) || out_instr16 !== ei || out_pc16 !== ep ||
          in_ready16 !== (q.size() < 2)) begin
        mismatched++;
        $display("FAIL params c=%0d: got v=%b i=%h pc=%h r=%b, want v=%b i=%h pc=%h r=%b",
                 c, out_valid16, out_instr16, out_pc16, in_ready16, q.size() > 0, ei, ep, q.size() < 2);
      end
      if (hold_chk) begin
        compared++;
        if (out_instr16 !== pi || out_pc16 !== pp || out_valid16 !== 1'b1) begin
          mismatched++;
          $display("FAIL params_hold c=%0d: got v=%b i=%h pc=%h, want v=1 i=%h pc=%h",
                   c, out_valid16, out_instr16, out_pc16, pi, pp);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
